mips_multicycle_control: RTL and testbench
==========================================

# mips_multicycle_control

Main control unit that sequences the MIPS datapath as a multicycle machine, replacing the single-cycle combinational decode. It issues per-cycle enables and mux selects to the PC, instruction/data memory, regfile, ULA and its `ula_control` (via the 2-bit `ula_operation`). It waits on a memory-ready handshake, halts on illegal opcodes and counts retired instructions.

## Interface
- `COUNT_WIDTH`, 32, width of the retired-instruction counter
- `HALT_ON_ILLEGAL`, 1, 1: illegal opcode enters HALT; 0: treated as NOP
- `clock`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `opcode`  in  6  instruction[31:26] from the instruction register
- `ula_zero_flag`  in  1  ULA zero output
- `mem_ready`  in  1  memory completes the current read/write this cycle
- `pc_en`  out  1  PC load enable (already includes the branch condition)
- `i_or_d`  out  1  memory address select: 0 PC, 1 ULA-out register
- `mem_read` / `mem_write`  out  1 each  memory strobes
- `ir_write`  out  1  instruction register load
- `reg_dst`  out  1  write address: 0 rt, 1 rd
- `mem_to_reg`  out  1  write data: 0 ULA-out, 1 memory data register
- `reg_write`  out  1  regfile write enable
- `ula_src_a`  out  1  0 PC, 1 register A
- `ula_src_b`  out  2  00 register B, 01 constant 4, 10 sign-ext imm, 11 sign-ext imm<<2
- `ula_operation`  out  2  00 add, 01 sub, 10 decode funct
- `pc_source`  out  2  00 ULA result, 01 ULA-out register, 10 jump target
- `instr_count`  out  COUNT_WIDTH  retired instructions
- `halted`  out  1  FSM in HALT

## Operation
- Opcodes: R 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000. Any other opcode is illegal.
- States and asserted outputs (unlisted outputs are 0):
  - FETCH: mem_read, i_or_d=0, ula_src_a=0, ula_src_b=01, ula_operation=00, pc_source=00; ir_write and pc_en only when mem_ready=1. Goes to DECODE when mem_ready=1, otherwise stays.
  - DECODE: ula_src_a=0, ula_src_b=11, ula_operation=00. Branches to the state for each opcode: lw/sw to MEMADDR, R to EXEC_R, beq to BRANCH, j to JUMP, addi to ADDI_EX. An illegal opcode goes to HALT, or to FETCH when HALT_ON_ILLEGAL=0.
  - MEMADDR: ula_src_a=1, ula_src_b=10, ula_operation=00. lw goes to MEMREAD, sw goes to MEMWRITE.
  - MEMREAD: mem_read, i_or_d=1. Goes to MEMWB on mem_ready.
  - MEMWB: reg_write, reg_dst=0, mem_to_reg=1. Goes to FETCH.
  - MEMWRITE: i_or_d=1; mem_write only while mem_ready=1. Goes to FETCH on mem_ready.
  - EXEC_R: ula_src_a=1, ula_src_b=00, ula_operation=10. Goes to RTYPE_WB.
  - RTYPE_WB: reg_write, reg_dst=1, mem_to_reg=0. Goes to FETCH.
  - BRANCH: ula_src_a=1, ula_src_b=00, ula_operation=01, pc_source=01, pc_en=ula_zero_flag. Goes to FETCH.
  - JUMP: pc_source=10, pc_en=1. Goes to FETCH.
  - ADDI_EX: ula_src_a=1, ula_src_b=10, ula_operation=00. Goes to ADDI_WB.
  - ADDI_WB: reg_write, reg_dst=0, mem_to_reg=0. Goes to FETCH.
  - HALT: all enables 0, halted=1. Stays in HALT until reset.
- Retirement: `instr_count` increments by 1 on every transition into FETCH from MEMWB, MEMWRITE, RTYPE_WB, BRANCH, JUMP or ADDI_WB. An illegal-opcode NOP (DECODE→FETCH) also counts.
- `instr_count` wraps modulo 2^COUNT_WIDTH. It holds its value in HALT.
- A branch that is not taken still retires.

## Timing
- Asynchronous reset (reset=0) sets state to FETCH, instr_count to 0 and halted to 0 immediately. While reset=0, pc_en, ir_write, mem_read, mem_write and reg_write are forced to 0. Select outputs take their FETCH values.
- The first fetch is issued on the first rising edge after reset deasserts.
- State, counter and halted are registered. Control outputs decode combinationally from state. pc_en, ir_write and mem_write also depend combinationally on mem_ready or ula_zero_flag in the same cycle.
- Latency with mem_ready held at 1: lw 5 cycles, sw 4, R 4, addi 4, beq 3, j 3, illegal NOP 2.
- Each cycle with mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds one cycle. No enable pulses during those wait cycles.
- `instr_count` updates on the same edge that enters FETCH.
- Reset asserted mid-instruction aborts it with no further enables. The aborted instruction is not counted.

## Test plan
- Reset then a stream of R, lw, sw, beq, j, addi with mem_ready=1 → state sequences as listed, latencies 4/5/4/3/3/4, instr_count=6 after 23 cycles.
- lw with mem_ready low for 3 cycles in both FETCH and MEMREAD → 11 cycles total; ir_write and pc_en pulse exactly once, reg_write exactly once.
- beq with ula_zero_flag=1, then beq with ula_zero_flag=0 → pc_en=1 with pc_source=01 in the first BRANCH, pc_en=0 in the second; both retire.
- opcode 111111 with HALT_ON_ILLEGAL=1 → HALT after DECODE, halted=1, all enables 0 for 20 cycles, count frozen. With HALT_ON_ILLEGAL=0 → returns to FETCH after 2 cycles and count increments.
- COUNT_WIDTH=4: 17 j instructions → instr_count=1. Reset asserted in MEMADDR → immediate FETCH, count 0, no mem_write.

Source files
------------

// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control
// ------------------------------------------------------------------------
// Multicycle main control FSM for the MIPS datapath. Each instruction is
// walked through FETCH / DECODE and an opcode-specific tail of states.
// Every cycle the FSM drives the datapath enables and mux selects.
// Memory accesses stall on mem_ready. An illegal opcode either halts the
// machine or is treated as a NOP. Retired instructions are counted.
//
// Parameters
//   COUNT_WIDTH      width of the retired-instruction counter (wraps)
//   HALT_ON_ILLEGAL  1: illegal opcode enters HALT, 0: retire it as a NOP
//
// Ports
//   clock          rising-edge clock
//   reset          asynchronous, active-low reset
//   opcode         instruction[31:26] from the instruction register
//   ula_zero_flag  ULA zero output (beq condition)
//   mem_ready      memory completes the current access this cycle
//   pc_en          PC load enable (branch condition already folded in)
//   i_or_d         memory address select: 0 PC, 1 ULA-out register
//   mem_read       memory read strobe
//   mem_write      memory write strobe
//   ir_write       instruction register load
//   reg_dst        regfile write address: 0 rt, 1 rd
//   mem_to_reg     regfile write data: 0 ULA-out, 1 memory data register
//   reg_write      regfile write enable
//   ula_src_a      ULA A operand: 0 PC, 1 register A
//   ula_src_b      ULA B operand: 00 B, 01 const 4, 10 imm, 11 imm<<2
//   ula_operation  00 add, 01 sub, 10 decode funct field
//   pc_source      00 ULA result, 01 ULA-out register, 10 jump target
//   instr_count    retired-instruction counter
//   halted         FSM is in HALT
// ------------------------------------------------------------------------
module mips_multicycle_control #(
    parameter int COUNT_WIDTH     = 32,
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [5:0]             opcode,
    input  logic                   ula_zero_flag,
    input  logic                   mem_ready,
    output logic                   pc_en,
    output logic                   i_or_d,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic                   ir_write,
    output logic                   reg_dst,
    output logic                   mem_to_reg,
    output logic                   reg_write,
    output logic                   ula_src_a,
    output logic [1:0]             ula_src_b,
    output logic [1:0]             ula_operation,
    output logic [1:0]             pc_source,
    output logic [COUNT_WIDTH-1:0] instr_count,
    output logic                   halted
);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADDR,
        MEMREAD,
        MEMWB,
        MEMWRITE,
        EXEC_R,
        RTYPE_WB,
        BRANCH,
        JUMP,
        ADDI_EX,
        ADDI_WB,
        HALT
    } state_t;

    state_t state;
    state_t next_state;

    logic pc_en_raw;
    logic ir_write_raw;
    logic mem_read_raw;
    logic mem_write_raw;
    logic reg_write_raw;
    logic retire;

    // Any entry into FETCH from a non-FETCH state ends an instruction,
    // including the DECODE->FETCH path of an illegal-opcode NOP. HALT never
    // leaves, so it cannot retire.
    assign retire = (next_state == FETCH) && (state != FETCH);

    // State, counter and halted flag. Reset aborts whatever instruction is
    // in flight without counting it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= FETCH;
            instr_count <= '0;
            halted      <= 1'b0;
        end else begin
            state  <= next_state;
            halted <= (next_state == HALT);
            if (retire) begin
                instr_count <= instr_count + COUNT_WIDTH'(1);
            end
        end
    end

    // Next-state and per-state control decode. Enables that wait on memory
    // or on the branch condition look at mem_ready / ula_zero_flag directly
    // so they fire in the same cycle the condition is seen.
    always_comb begin
        next_state    = state;
        pc_en_raw     = 1'b0;
        ir_write_raw  = 1'b0;
        mem_read_raw  = 1'b0;
        mem_write_raw = 1'b0;
        reg_write_raw = 1'b0;
        i_or_d        = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        ula_src_a     = 1'b0;
        ula_src_b     = 2'b00;
        ula_operation = 2'b00;
        pc_source     = 2'b00;

        case (state)
            FETCH: begin
                mem_read_raw = 1'b1;
                ula_src_b    = 2'b01;
                if (mem_ready) begin
                    ir_write_raw = 1'b1;
                    pc_en_raw    = 1'b1;
                    next_state   = DECODE;
                end
            end
            DECODE: begin
                // Branch target PC + (imm<<2) is precomputed here.
                ula_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: next_state = MEMADDR;
                    OP_R:         next_state = EXEC_R;
                    OP_BEQ:       next_state = BRANCH;
                    OP_J:         next_state = JUMP;
                    OP_ADDI:      next_state = ADDI_EX;
                    default:      next_state = HALT_ON_ILLEGAL ? HALT : FETCH;
                endcase
            end
            MEMADDR: begin
                ula_src_a  = 1'b1;
                ula_src_b  = 2'b10;
                next_state = (opcode == OP_SW) ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                mem_read_raw = 1'b1;
                i_or_d       = 1'b1;
                if (mem_ready) begin
                    next_state = MEMWB;
                end
            end
            MEMWB: begin
                reg_write_raw = 1'b1;
                mem_to_reg    = 1'b1;
                next_state    = FETCH;
            end
            MEMWRITE: begin
                i_or_d = 1'b1;
                if (mem_ready) begin
                    mem_write_raw = 1'b1;
                    next_state    = FETCH;
                end
            end
            EXEC_R: begin
                ula_src_a     = 1'b1;
                ula_operation = 2'b10;
                next_state    = RTYPE_WB;
            end
            RTYPE_WB: begin
                reg_write_raw = 1'b1;
                reg_dst       = 1'b1;
                next_state    = FETCH;
            end
            BRANCH: begin
                ula_src_a     = 1'b1;
                ula_operation = 2'b01;
                pc_source     = 2'b01;
                pc_en_raw     = ula_zero_flag;
                next_state    = FETCH;
            end
            JUMP: begin
                pc_source  = 2'b10;
                pc_en_raw  = 1'b1;
                next_state = FETCH;
            end
            ADDI_EX: begin
                ula_src_a  = 1'b1;
                ula_src_b  = 2'b10;
                next_state = ADDI_WB;
            end
            ADDI_WB: begin
                reg_write_raw = 1'b1;
                next_state    = FETCH;
            end
            HALT: begin
                next_state = HALT;
            end
            default: begin
                next_state = FETCH;
            end
        endcase
    end

    // While reset is low the state already reads FETCH, so selects show
    // their FETCH values; only the enables need masking.
    assign pc_en     = pc_en_raw     & reset;
    assign ir_write  = ir_write_raw  & reset;
    assign mem_read  = mem_read_raw  & reset;
    assign mem_write = mem_write_raw & reset;
    assign reg_write = reg_write_raw & reset;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb_mips_multicycle_control
// ------------------------------------------------------------------------
// Two instances: dut_a with default parameters (32-bit count, halt on
// illegal) and dut_b with a 4-bit count and illegal opcodes as NOPs.
// The driver pushes the expected control vector and count for every cycle
// it drives; the monitor pops one entry per falling edge and compares.
// ------------------------------------------------------------------------
module tb_mips_multicycle_control;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    typedef struct {
        logic [15:0] ctl;
        logic [31:0] cnt;
        bit          sel;
        string       tag;
    } exp_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset_a = 1'b0, reset_b = 1'b0;
    logic [5:0] opcode_a = '0, opcode_b = '0;
    logic       zero_a = 1'b0, zero_b = 1'b0;
    logic       ready_a = 1'b1, ready_b = 1'b1;

    logic       pc_en_a, i_or_d_a, mem_read_a, mem_write_a, ir_write_a;
    logic       reg_dst_a, mem_to_reg_a, reg_write_a, ula_src_a_a, halted_a;
    logic [1:0] ula_src_b_a, ula_op_a, pc_source_a;
    logic [31:0] count_a;

    logic       pc_en_b, i_or_d_b, mem_read_b, mem_write_b, ir_write_b;
    logic       reg_dst_b, mem_to_reg_b, reg_write_b, ula_src_a_b, halted_b;
    logic [1:0] ula_src_b_b, ula_op_b, pc_source_b;
    logic [3:0] count_b;

    mips_multicycle_control dut_a (
        .clock(clock), .reset(reset_a), .opcode(opcode_a),
        .ula_zero_flag(zero_a), .mem_ready(ready_a),
        .pc_en(pc_en_a), .i_or_d(i_or_d_a), .mem_read(mem_read_a),
        .mem_write(mem_write_a), .ir_write(ir_write_a), .reg_dst(reg_dst_a),
        .mem_to_reg(mem_to_reg_a), .reg_write(reg_write_a),
        .ula_src_a(ula_src_a_a), .ula_src_b(ula_src_b_a),
        .ula_operation(ula_op_a), .pc_source(pc_source_a),
        .instr_count(count_a), .halted(halted_a)
    );

    mips_multicycle_control #(.COUNT_WIDTH(4), .HALT_ON_ILLEGAL(1'b0)) dut_b (
        .clock(clock), .reset(reset_b), .opcode(opcode_b),
        .ula_zero_flag(zero_b), .mem_ready(ready_b),
        .pc_en(pc_en_b), .i_or_d(i_or_d_b), .mem_read(mem_read_b),
        .mem_write(mem_write_b), .ir_write(ir_write_b), .reg_dst(reg_dst_b),
        .mem_to_reg(mem_to_reg_b), .reg_write(reg_write_b),
        .ula_src_a(ula_src_a_b), .ula_src_b(ula_src_b_b),
        .ula_operation(ula_op_b), .pc_source(pc_source_b),
        .instr_count(count_b), .halted(halted_b)
    );

    logic [15:0] ctl_a, ctl_b;
    assign ctl_a = {pc_en_a, i_or_d_a, mem_read_a, mem_write_a, ir_write_a,
                    reg_dst_a, mem_to_reg_a, reg_write_a, ula_src_a_a,
                    ula_src_b_a, ula_op_a, pc_source_a, halted_a};
    assign ctl_b = {pc_en_b, i_or_d_b, mem_read_b, mem_write_b, ir_write_b,
                    reg_dst_b, mem_to_reg_b, reg_write_b, ula_src_a_b,
                    ula_src_b_b, ula_op_b, pc_source_b, halted_b};

    exp_t        sb[$];
    exp_t        mon_e;
    logic [15:0] act_ctl;
    logic [31:0] act_cnt;
    int          checks = 0;
    int          errors = 0;

    bit          sel = 1'b0;
    logic [31:0] cnt_a = '0;
    logic [3:0]  cnt_b = '0;

    // Expected control vector, same bit order as ctl_a/ctl_b.
    function automatic logic [15:0] v(
        input logic pe, input logic iod, input logic mr, input logic mw,
        input logic irw, input logic rd, input logic m2r, input logic rw,
        input logic sa, input logic [1:0] sbv, input logic [1:0] op,
        input logic [1:0] ps, input logic h);
        return {pe, iod, mr, mw, irw, rd, m2r, rw, sa, sbv, op, ps, h};
    endfunction

    // Monitor: one comparison per cycle the driver described.
    always @(negedge clock) begin
        if (sb.size() != 0) begin
            mon_e   = sb.pop_front();
            act_ctl = mon_e.sel ? ctl_b : ctl_a;
            act_cnt = mon_e.sel ? {28'd0, count_b} : count_a;
            checks  = checks + 1;
            if (act_ctl !== mon_e.ctl || act_cnt !== mon_e.cnt) begin
                errors = errors + 1;
                $display("[TB] FAIL %s: ctl actual %b required %b, count actual %0d required %0d",
                         mon_e.tag, act_ctl, mon_e.ctl, act_cnt, mon_e.cnt);
            end
        end
    end

    task automatic cycle(input logic [15:0] c, input string tag);
        exp_t e;
        e.ctl = c;
        e.cnt = sel ? {28'd0, cnt_b} : cnt_a;
        e.sel = sel;
        e.tag = tag;
        sb.push_back(e);
        @(posedge clock);
        #1;
    endtask

    task automatic retire();
        if (sel) cnt_b = cnt_b + 4'd1;
        else     cnt_a = cnt_a + 32'd1;
    endtask

    task automatic set_in(input logic [5:0] op, input logic rdy, input logic z);
        if (sel) begin
            opcode_b = op; ready_b = rdy; zero_b = z;
        end else begin
            opcode_a = op; ready_a = rdy; zero_a = z;
        end
    endtask

    task automatic set_reset(input logic r);
        if (sel) reset_b = r;
        else     reset_a = r;
    endtask

    // Reset: enables low, selects at their FETCH values, count cleared.
    task automatic apply_reset(input string tag);
        set_reset(1'b0);
        if (sel) cnt_b = '0;
        else     cnt_a = '0;
        cycle(v(0,0,0,0,0,0,0,0,0,2'b01,2'b00,2'b00,0), tag);
        set_reset(1'b1);
    endtask

    task automatic fetch_decode(input logic [5:0] op, input int fw, input logic z);
        for (int i = 0; i < fw; i++) begin
            set_in(op, 1'b0, z);
            cycle(v(0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0), "fetch_wait");
        end
        set_in(op, 1'b1, z);
        cycle(v(1,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00,0), "fetch");
        cycle(v(0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0), "decode");
    endtask

    task automatic run_instr(input logic [5:0] op, input int fw, input int mwait, input logic z);
        fetch_decode(op, fw, z);
        case (op)
            OP_R: begin
                cycle(v(0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0), "exec_r");
                cycle(v(0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,0), "rtype_wb");
                retire();
            end
            OP_LW: begin
                cycle(v(0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0), "memaddr_lw");
                for (int i = 0; i < mwait; i++) begin
                    set_in(op, 1'b0, z);
                    cycle(v(0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0), "memread_wait");
                end
                set_in(op, 1'b1, z);
                cycle(v(0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0), "memread");
                cycle(v(0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,0), "memwb");
                retire();
            end
            OP_SW: begin
                cycle(v(0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0), "memaddr_sw");
                for (int i = 0; i < mwait; i++) begin
                    set_in(op, 1'b0, z);
                    cycle(v(0,1,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,0), "memwrite_wait");
                end
                set_in(op, 1'b1, z);
                cycle(v(0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0), "memwrite");
                retire();
            end
            OP_BEQ: begin
                cycle(v(z,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0), z ? "branch_taken" : "branch_not_taken");
                retire();
            end
            OP_J: begin
                cycle(v(1,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,0), "jump");
                retire();
            end
            OP_ADDI: begin
                cycle(v(0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0), "addi_ex");
                cycle(v(0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,0), "addi_wb");
                retire();
            end
            default: begin
                // Illegal: dut_b retires it in DECODE, dut_a goes to HALT.
                if (sel) retire();
            end
        endcase
    endtask

    // Idle FETCH cycle with memory not ready: shows the count in between.
    task automatic probe_count(input string tag);
        set_in(OP_R, 1'b0, 1'b0);
        cycle(v(0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0), tag);
    endtask

    task automatic applyStimulus();
        @(posedge clock);
        #1;
        sel = 1'b0;
        apply_reset("reset_a");

        // Full instruction mix with memory always ready: 4+5+4+3+3+4 cycles.
        run_instr(OP_R,    0, 0, 1'b0);
        run_instr(OP_LW,   0, 0, 1'b0);
        run_instr(OP_SW,   0, 0, 1'b0);
        run_instr(OP_BEQ,  0, 0, 1'b1);
        run_instr(OP_J,    0, 0, 1'b0);
        run_instr(OP_ADDI, 0, 0, 1'b0);
        probe_count("count_after_mix");

        // lw with three wait cycles in FETCH and in MEMREAD.
        run_instr(OP_LW, 3, 3, 1'b0);
        // sw with write wait cycles.
        run_instr(OP_SW, 1, 2, 1'b0);
        // Taken then not-taken branch; both retire.
        run_instr(OP_BEQ, 0, 0, 1'b1);
        run_instr(OP_BEQ, 0, 0, 1'b0);
        probe_count("count_after_beq");

        // Abort a sw in MEMADDR with reset: no write, count cleared.
        fetch_decode(OP_SW, 0, 1'b0);
        apply_reset("reset_in_memaddr");
        probe_count("after_abort");
        run_instr(OP_J, 0, 0, 1'b0);

        // Illegal opcode halts: 20 cycles of no enables, count frozen.
        run_instr(OP_BAD, 0, 0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            set_in(OP_R, i[0], i[1]);
            cycle(v(0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,1), "halt");
        end
        apply_reset("reset_from_halt");
        reset_a = 1'b0;

        // Second instance: 4-bit counter wrap and illegal-as-NOP.
        sel = 1'b1;
        apply_reset("reset_b");
        for (int i = 0; i < 17; i++) begin
            run_instr(OP_J, 0, 0, 1'b0);
        end
        probe_count("count_wrap");
        run_instr(OP_BAD, 0, 0, 1'b0);
        probe_count("count_after_nop");
        run_instr(OP_ADDI, 0, 0, 1'b0);
    endtask

    task automatic checkOutput();
        int budget;
        budget = 0;
        while (sb.size() != 0 && budget < 20) begin
            @(posedge clock);
            budget++;
        end
        if (sb.size() != 0) begin
            errors = errors + 1;
            $display("[TB] FAIL drain: pending %0d required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask

    initial begin
        applyStimulus();
        checkOutput();
    end

    // Overall time guard.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish, checks %0d", checks);
        $fatal(1, "[TB] timeout");
    end

endmodule
